vending_machine_multi: RTL and testbench

VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

---
 rtl/vending_pkg.sv | 32 +++
 rtl/coin_decode.sv | 13 +
 rtl/vending_machine_multi.sv | 111 +++++++++++
 tb/tb_vending_machine_multi.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and coin-code constants for the multi-coin vending machine.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_e;

    localparam logic [1:0] COIN_1   = 2'b00;
    localparam logic [1:0] COIN_2   = 2'b01;
    localparam logic [1:0] COIN_5   = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam logic [2:0] UNITS_1 = 3'd1;
    localparam logic [2:0] UNITS_2 = 3'd2;
    localparam logic [2:0] UNITS_5 = 3'd5;

    // Unit value of a denomination code; the invalid code maps to 0.
    function automatic logic [2:0] coin_units(input logic [1:0] code);
        logic [2:0] units;
        units = 3'd0;
        case (code)
            COIN_1:  units = UNITS_1;
            COIN_2:  units = UNITS_2;
            COIN_5:  units = UNITS_5;
            default: units = 3'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/coin_decode.sv
// Combinational coin decoder: denomination code to unit value plus valid flag.
module coin_decode
    import vending_pkg::*;
(
    input  logic [1:0] coin_val_i,
    output logic [2:0] units_o,
    output logic       valid_o
);

    assign units_o = coin_units(coin_val_i);
    assign valid_o = (coin_val_i != COIN_BAD);

endmodule

// File: rtl/vending_machine_multi.sv
// Toy vending machine: accumulates 1/2/5-unit coins, vends at PRICE, then pays
// back the remainder one unit per cycle. Cancel refunds the held credit.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 15,
    parameter int CREDIT_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin,
    input  logic [1:0]          coin_val,
    input  logic                cancel,
    output logic                toy,
    output logic                change,
    output logic                reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_N = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_N   = CREDIT_W'(1);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic [2:0]          coin_units_w;
    logic                coin_valid_w;
    logic [CREDIT_W:0]   sum_wide;
    logic                coin_fits;

    coin_decode u_coin_decode (
        .coin_val_i (coin_val),
        .units_o    (coin_units_w),
        .valid_o    (coin_valid_w)
    );

    // One extra bit so the overflow compare against MAX_CREDIT cannot wrap.
    assign sum_wide  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_units_w);
    assign coin_fits = coin_valid_w && (sum_wide <= MAX_W);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cancel) begin
                    reject_d = coin;
                    if (credit_q != '0) begin
                        state_d = CHANGE;
                    end
                end else begin
                    if (coin) begin
                        if (coin_fits) begin
                            credit_d = credit_q + CREDIT_W'(coin_units_w);
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                    if (credit_d >= PRICE_N) begin
                        state_d = VEND;
                    end
                end
            end
            VEND: begin
                reject_d = coin;
                credit_d = credit_q - PRICE_N;
                state_d  = (credit_d != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin;
                if (credit_q != '0) begin
                    credit_d = credit_q - ONE_N;
                end
                if (credit_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Moore outputs straight from the state register, so reset clears them at once.
    assign toy       = (state_q == VEND);
    assign change    = (state_q == CHANGE);
    assign busy      = (state_q != IDLE);
    assign reject    = reject_q;
    assign credit    = credit_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: obligation-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_vending_machine_multi;

  localparam int PRICE = 3;
  localparam int MAXC  = 15;
  localparam int W     = 4;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         coin, cancel;
  logic [1:0]   coin_val;
  logic         toy, change, reject, busy;
  logic [W-1:0] credit;
  logic [1:0]   dbg_state;

  logic         coin12, cancel12;
  logic [1:0]   coin_val12;
  logic         toy12, change12, reject12, busy12;
  logic [W-1:0] credit12;
  logic [1:0]   dbg_state12;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  vending_machine_multi #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(W)) dut (
    .clock     (clock),
    .reset     (rst_n),
    .coin      (coin),
    .coin_val  (coin_val),
    .cancel    (cancel),
    .toy       (toy),
    .change    (change),
    .reject    (reject),
    .credit    (credit),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  vending_machine_multi #(.PRICE(12), .MAX_CREDIT(MAXC), .CREDIT_W(W)) dut12 (
    .clock     (clock),
    .reset     (rst_n),
    .coin      (coin12),
    .coin_val  (coin_val12),
    .cancel    (cancel12),
    .toy       (toy12),
    .change    (change12),
    .reject    (reject12),
    .credit    (credit12),
    .busy      (busy12),
    .dbg_state (dbg_state12)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The machine is tracked as held credit plus outstanding obligations:
  // a toy still owed, and a number of change units still owed.
  int m_credit;
  bit m_toy_owed;
  int m_change_owed;
  bit m_reject;

  function automatic int coin_value(input logic [1:0] code);
    int table_v[4] = '{1, 2, 5, -1};
    return table_v[code];
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_credit      <= 0;
      m_toy_owed    <= 1'b0;
      m_change_owed <= 0;
      m_reject      <= 1'b0;
    end else begin
      automatic int n_credit = m_credit;
      automatic bit n_toy    = 1'b0;
      automatic int n_chg    = m_change_owed;
      automatic bit n_rej    = 1'b0;
      automatic int v;
      if (m_toy_owed) begin
        n_credit = m_credit - PRICE;
        n_chg    = n_credit;
        n_rej    = coin;
      end else if (m_change_owed > 0) begin
        n_credit = m_credit - 1;
        n_chg    = m_change_owed - 1;
        n_rej    = coin;
      end else if (cancel) begin
        n_chg = m_credit;
        n_rej = coin;
      end else begin
        if (coin) begin
          v = coin_value(coin_val);
          if (v < 0 || m_credit + v > MAXC) n_rej = 1'b1;
          else n_credit = m_credit + v;
        end
        n_toy = (n_credit >= PRICE);
      end
      m_credit      <= n_credit;
      m_toy_owed    <= n_toy;
      m_change_owed <= n_chg;
      m_reject      <= n_rej;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cyc_toy",    toy,    m_toy_owed);
      chk("cyc_change", change, (!m_toy_owed && m_change_owed > 0));
      chk("cyc_reject", reject, m_reject);
      chk("cyc_credit", credit, m_credit);
      chk("cyc_busy",   busy,   (m_toy_owed || m_change_owed > 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic c, input logic [1:0] v, input logic k);
    coin     = c;
    coin_val = v;
    cancel   = k;
    @(posedge clock);
    #1;
  endtask

  task automatic step12(input logic c, input logic [1:0] v);
    coin12     = c;
    coin_val12 = v;
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    coin = 1'b0; coin_val = 2'b00; cancel = 1'b0;
    coin12 = 1'b0; coin_val12 = 2'b00; cancel12 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_toy",    toy,    0);
    chk("rst_change", change, 0);
    chk("rst_reject", reject, 0);
    chk("rst_busy",   busy,   0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // coin 1 then coin 2: exact price, no change
    step(1, 2'b00, 0); chk("s1_credit1", credit, 1); chk("s1_toy0", toy, 0);
    step(1, 2'b01, 0); chk("s1_credit3", credit, 3); chk("s1_toy", toy, 1);
    step(0, 2'b00, 0); chk("s1_toy_off", toy, 0); chk("s1_credit0", credit, 0);
    chk("s1_change", change, 0); chk("s1_busy", busy, 0);

    // coin 5: toy then two change pulses
    step(1, 2'b10, 0); chk("s2_toy", toy, 1); chk("s2_credit5", credit, 5);
    step(0, 2'b00, 0); chk("s2_chg1", change, 1); chk("s2_credit2", credit, 2);
    step(0, 2'b00, 0); chk("s2_chg2", change, 1); chk("s2_credit1", credit, 1);
    step(0, 2'b00, 0); chk("s2_chg_done", change, 0); chk("s2_credit0", credit, 0);
    chk("s2_busy", busy, 0);

    // coin 2, then cancel with a simultaneous coin 1
    step(1, 2'b01, 0); chk("s3_credit2", credit, 2);
    step(1, 2'b00, 1); chk("s3_reject", reject, 1); chk("s3_chg1", change, 1);
    chk("s3_toy", toy, 0);
    step(0, 2'b00, 0); chk("s3_chg2", change, 1); chk("s3_reject_off", reject, 0);
    step(0, 2'b00, 0); chk("s3_chg_done", change, 0); chk("s3_credit0", credit, 0);
    // invalid code with credit held, then cancel on credit 0 with coin
    step(1, 2'b00, 0); chk("s3_credit1", credit, 1);
    step(1, 2'b11, 0); chk("s3_bad_reject", reject, 1); chk("s3_bad_credit", credit, 1);
    step(0, 2'b00, 1); chk("s3_refund", change, 1);
    step(0, 2'b00, 0); chk("s3_refund_done", credit, 0);
    step(1, 2'b01, 1); chk("s3_cancel0_reject", reject, 1); chk("s3_cancel0_busy", busy, 0);

    // reset during the first change pulse
    step(1, 2'b10, 0); chk("s4_toy", toy, 1);
    step(0, 2'b00, 0); chk("s4_chg", change, 1); chk("s4_credit2", credit, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_rst_credit", credit, 0); chk("s4_rst_change", change, 0);
    chk("s4_rst_toy", toy, 0); chk("s4_rst_busy", busy, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    step(1, 2'b00, 0); chk("s4_credit1", credit, 1); chk("s4_no_toy", toy, 0);
    chk("s4_no_change", change, 0);
    step(0, 2'b00, 1); step(0, 2'b00, 0);

    // coin held four cycles with code 00
    step(1, 2'b00, 0); chk("s5_c1", credit, 1);
    step(1, 2'b00, 0); chk("s5_c2", credit, 2);
    step(1, 2'b00, 0); chk("s5_c3", credit, 3); chk("s5_toy", toy, 1);
    step(1, 2'b00, 0); chk("s5_reject", reject, 1); chk("s5_credit0", credit, 0);
    chk("s5_busy", busy, 0);
    step(0, 2'b00, 0);

    // PRICE=12 instance
    step12(1, 2'b10); step12(1, 2'b10); step12(1, 2'b00);
    chk("p12_credit11", credit12, 11);
    step12(1, 2'b10); chk("p12_reject", reject12, 1); chk("p12_credit_kept", credit12, 11);
    step12(1, 2'b00); chk("p12_credit12", credit12, 12); chk("p12_toy", toy12, 1);
    step12(0, 2'b00); chk("p12_credit0", credit12, 0); chk("p12_no_change", change12, 0);
    chk("p12_busy", busy12, 0);

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      step($urandom_range(0, 99) < 45, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 8);
    end
    step(0, 2'b00, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
